mem_access_unit: RTL and testbench

- MEM-stage data-memory access controller. Sits between the EX/MEM pipeline register and MEM_WB, and produces the Read_data_MEM value that MEM_WB latches.
- Converts load/store control from EX/MEM into a req/ack transaction on an external word-wide data bus.
- Handles byte/half/word lanes, sign or zero extension, and misalignment detection.
- Stalls the pipeline until the bus acknowledges or a timeout expires.

---
 rtl/mem_access_unit.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// MEM-stage data-memory access controller. Turns the load/store control held
// in EX/MEM into a single req/ack transaction on a word-wide data bus, handles
// byte/half/word lanes with sign or zero extension, flags misaligned or
// malformed accesses, and stalls the pipeline until the bus acknowledges or a
// timeout expires.
//
// Ports
//   clk, rst_n       : clock (rising edge), asynchronous active-low reset
//   mem_read/write   : load / store in MEM stage
//   mem_size         : 00 byte, 01 half, 10 word, 11 reserved (error)
//   mem_unsigned     : 1 = zero-extend load, 0 = sign-extend
//   ALU_result_MEM   : byte address
//   Write_data_MEM   : store data (low bits significant for byte/half)
//   Read_data_MEM    : registered, extended load data to MEM_WB
//   stall_MEM        : hold the upstream pipeline this cycle
//   err_MEM          : one-cycle access-error flag (illegal access or timeout)
//   dmem_*           : external data bus (word address, lane enables, ack)
// ---------------------------------------------------------------------------
module mem_access_unit #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic [31:0] ALU_result_MEM,
    input  logic [31:0] Write_data_MEM,
    output logic [31:0] Read_data_MEM,
    output logic        stall_MEM,
    output logic        err_MEM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    // Select the addressed lane from a bus word and extend it to 32 bits.
    function automatic logic [31:0] extract_load(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic [1:0]  lane,
        input logic        uns
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'h00;
        h = 16'h0000;
        r = 32'h0000_0000;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'h00;
        endcase
        if (lane[1]) begin
            h = word[31:16];
        end else begin
            h = word[15:0];
        end
        case (size)
            2'b00:   r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
            2'b01:   r = uns ? {16'h0000, h}   : {{16{h[15]}}, h};
            2'b10:   r = word;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    // State and captured transaction
    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic             tmo_r;
    logic             req_r;
    logic             we_r;
    logic [31:0]      addr_r;
    logic [31:0]      wdata_r;
    logic [3:0]       be_r;
    logic [1:0]       size_r;
    logic             uns_r;
    logic [1:0]       lane_r;
    logic [31:0]      rdata_r;

    // Decode of the instruction presented at the inputs
    logic             any_access_s;
    logic             aligned_s;
    logic             legal_s;
    logic [3:0]       be_s;
    logic [31:0]      wdata_s;
    logic             timeout_hit_s;

    // Legality check and lane/byte-enable generation for the incoming access.
    always_comb begin
        any_access_s = mem_read | mem_write;
        case (mem_size)
            2'b00:   aligned_s = 1'b1;
            2'b01:   aligned_s = ~ALU_result_MEM[0];
            2'b10:   aligned_s = (ALU_result_MEM[1:0] == 2'b00);
            default: aligned_s = 1'b0;
        endcase
        legal_s = (mem_read ^ mem_write) & aligned_s;
        case (mem_size)
            2'b00: begin
                be_s    = 4'b0001 << ALU_result_MEM[1:0];
                wdata_s = {4{Write_data_MEM[7:0]}};
            end
            2'b01: begin
                be_s    = ALU_result_MEM[1] ? 4'b1100 : 4'b0011;
                wdata_s = {2{Write_data_MEM[15:0]}};
            end
            2'b10: begin
                be_s    = 4'b1111;
                wdata_s = Write_data_MEM;
            end
            default: begin
                be_s    = 4'b0000;
                wdata_s = 32'h0000_0000;
            end
        endcase
    end

    // Ack takes priority over timeout when both land in the same cycle.
    always_comb begin
        timeout_hit_s = (cnt_r == CNT_LAST) & ~dmem_ack;
    end

    // Next-state logic for IDLE / WAIT / DONE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (legal_s) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (dmem_ack || timeout_hit_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Stall and error flags; gated by rst_n so they fall as soon as reset asserts.
    always_comb begin
        stall_MEM = 1'b0;
        err_MEM   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                stall_MEM = rst_n & legal_s;
                err_MEM   = rst_n & any_access_s & ~legal_s;
            end
            ST_WAIT: begin
                stall_MEM = rst_n;
                err_MEM   = 1'b0;
            end
            ST_DONE: begin
                stall_MEM = 1'b0;
                err_MEM   = rst_n & tmo_r;
            end
            default: begin
                stall_MEM = 1'b0;
                err_MEM   = 1'b0;
            end
        endcase
    end

    // FSM state, timeout counter and bus request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            tmo_r   <= 1'b0;
            req_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= {CNT_W{1'b0}};
                    tmo_r <= 1'b0;
                    req_r <= legal_s;
                end
                ST_WAIT: begin
                    if (dmem_ack) begin
                        req_r <= 1'b0;
                        tmo_r <= 1'b0;
                    end else if (timeout_hit_s) begin
                        req_r <= 1'b0;
                        tmo_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    req_r <= 1'b0;
                end
                default: begin
                    req_r <= 1'b0;
                    tmo_r <= 1'b0;
                end
            endcase
        end
    end

    // Captured bus fields; loaded only when a legal access is accepted in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_r    <= 1'b0;
            addr_r  <= 32'h0000_0000;
            wdata_r <= 32'h0000_0000;
            be_r    <= 4'b0000;
            size_r  <= 2'b00;
            uns_r   <= 1'b0;
            lane_r  <= 2'b00;
        end else if ((state_r == ST_IDLE) && legal_s) begin
            we_r    <= mem_write;
            addr_r  <= {ALU_result_MEM[31:2], 2'b00};
            wdata_r <= wdata_s;
            be_r    <= be_s;
            size_r  <= mem_size;
            uns_r   <= mem_unsigned;
            lane_r  <= ALU_result_MEM[1:0];
        end else begin
            we_r    <= we_r;
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
            be_r    <= be_r;
            size_r  <= size_r;
            uns_r   <= uns_r;
            lane_r  <= lane_r;
        end
    end

    // Load result register: updated only when a load completes or times out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= 32'h0000_0000;
        end else if ((state_r == ST_WAIT) && !we_r) begin
            if (dmem_ack) begin
                rdata_r <= extract_load(dmem_rdata, size_r, lane_r, uns_r);
            end else if (timeout_hit_s) begin
                rdata_r <= 32'h0000_0000;
            end else begin
                rdata_r <= rdata_r;
            end
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign Read_data_MEM = rdata_r;
    assign dmem_req      = req_r;
    assign dmem_we       = we_r;
    assign dmem_addr     = addr_r;
    assign dmem_wdata    = wdata_r;
    assign dmem_be       = be_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
// Directed self-checking bench for mem_access_unit (TIMEOUT = 4). Inputs are
// driven 1 time unit after the rising edge and outputs compared 1 unit later.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic [31:0] ALU_result_MEM;
    logic [31:0] Write_data_MEM;
    logic [31:0] Read_data_MEM;
    logic        stall_MEM;
    logic        err_MEM;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_access_unit #(.TIMEOUT(4), .CNT_W(5)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_size       (mem_size),
        .mem_unsigned   (mem_unsigned),
        .ALU_result_MEM (ALU_result_MEM),
        .Write_data_MEM (Write_data_MEM),
        .Read_data_MEM  (Read_data_MEM),
        .stall_MEM      (stall_MEM),
        .err_MEM        (err_MEM),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_be        (dmem_be),
        .dmem_rdata     (dmem_rdata),
        .dmem_ack       (dmem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wd);
        mem_read       = r;
        mem_write      = w;
        mem_size       = sz;
        mem_unsigned   = uns;
        ALU_result_MEM = addr;
        Write_data_MEM = wd;
        #1;
    endtask

    task automatic clear_in();
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    endtask

    // Present a legal access, step into WAIT, ack after (waits) extra WAIT cycles, land in DONE.
    task automatic acked_access(input logic r, input logic w, input logic [1:0] sz,
                                input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                                input int waits, input logic [31:0] rd);
        drive(r, w, sz, uns, addr, wd);
        step();
        for (int i = 0; i < waits; i++) step();
        dmem_ack   = 1'b1;
        dmem_rdata = rd;
        step();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
    endtask

    initial begin
        rst_n = 1'b0;
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        clear_in();
        step();
        check("rst_rdata", Read_data_MEM, 32'h0);
        check("rst_req", {31'h0, dmem_req}, 32'h0);
        check("rst_stall", {31'h0, stall_MEM}, 32'h0);
        check("rst_err", {31'h0, err_MEM}, 32'h0);
        check("rst_addr", dmem_addr, 32'h0);
        check("rst_be", {28'h0, dmem_be}, 32'h0);
        rst_n = 1'b1;
        step();

        // 1. word load 0x104, ack on 2nd WAIT cycle
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0104, 32'h0);
        check("t1_idle_stall", {31'h0, stall_MEM}, 32'h1);
        check("t1_idle_req", {31'h0, dmem_req}, 32'h0);
        step();
        check("t1_w1_req", {31'h0, dmem_req}, 32'h1);
        check("t1_w1_stall", {31'h0, stall_MEM}, 32'h1);
        check("t1_addr", dmem_addr, 32'h0000_0104);
        check("t1_be", {28'h0, dmem_be}, 32'hF);
        check("t1_we", {31'h0, dmem_we}, 32'h0);
        step();
        check("t1_w2_stall", {31'h0, stall_MEM}, 32'h1);
        dmem_ack = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        step();
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        check("t1_done_rdata", Read_data_MEM, 32'hDEAD_BEEF);
        check("t1_done_stall", {31'h0, stall_MEM}, 32'h0);
        check("t1_done_req", {31'h0, dmem_req}, 32'h0);
        check("t1_done_err", {31'h0, err_MEM}, 32'h0);
        step();
        clear_in();

        // 2. signed then unsigned byte load at 0x103
        drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0);
        step();
        check("t2_be", {28'h0, dmem_be}, 32'h8);
        check("t2_addr", dmem_addr, 32'h0000_0100);
        dmem_ack = 1'b1;
        dmem_rdata = 32'h80AA_BBCC;
        step();
        dmem_ack = 1'b0;
        check("t2_sbyte", Read_data_MEM, 32'hFFFF_FF80);
        step();
        acked_access(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0, 0, 32'h80AA_BBCC);
        check("t2_ubyte", Read_data_MEM, 32'h0000_0080);
        step();

        // signed half load from upper half at 0x106
        acked_access(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0106, 32'h0, 1, 32'h9ABC_1234);
        check("t2_shalf_hi", Read_data_MEM, 32'hFFFF_9ABC);
        step();
        acked_access(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0104, 32'h0, 0, 32'h1234_8001);
        check("t2_uhalf_lo", Read_data_MEM, 32'h0000_8001);
        step();

        // 3. half store at 0x102
        drive(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0102, 32'h1234_5678);
        step();
        check("t3_we", {31'h0, dmem_we}, 32'h1);
        check("t3_be", {28'h0, dmem_be}, 32'hC);
        check("t3_wdata", dmem_wdata, 32'h5678_5678);
        dmem_ack = 1'b1;
        dmem_rdata = 32'hFFFF_FFFF;
        step();
        dmem_ack = 1'b0;
        check("t3_rdata_kept", Read_data_MEM, 32'h0000_8001);
        step();

        // byte store at 0x101
        drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0101, 32'h0000_00A5);
        step();
        check("t3b_be", {28'h0, dmem_be}, 32'h2);
        check("t3b_wdata", dmem_wdata, 32'hA5A5_A5A5);
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        step();

        // 4. illegal accesses
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0);
        check("t4_mis_err", {31'h0, err_MEM}, 32'h1);
        check("t4_mis_stall", {31'h0, stall_MEM}, 32'h0);
        step();
        check("t4_mis_req", {31'h0, dmem_req}, 32'h0);
        drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'h0);
        check("t4_rw_err", {31'h0, err_MEM}, 32'h1);
        check("t4_rw_stall", {31'h0, stall_MEM}, 32'h0);
        step();
        check("t4_rw_req", {31'h0, dmem_req}, 32'h0);
        drive(1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'h0);
        check("t4_sz_err", {31'h0, err_MEM}, 32'h1);
        step();
        check("t4_sz_req", {31'h0, dmem_req}, 32'h0);
        clear_in();
        check("t4_err_clear", {31'h0, err_MEM}, 32'h0);
        check("t4_rdata_kept", Read_data_MEM, 32'h0000_8001);

        // 5. timeout, then a late ack in DONE is ignored
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("t5_req_w%0d", i), {31'h0, dmem_req}, 32'h1);
        end
        step();
        check("t5_done_req", {31'h0, dmem_req}, 32'h0);
        check("t5_done_err", {31'h0, err_MEM}, 32'h1);
        check("t5_done_stall", {31'h0, stall_MEM}, 32'h0);
        check("t5_done_rdata", Read_data_MEM, 32'h0);
        dmem_ack = 1'b1;
        dmem_rdata = 32'h5555_AAAA;
        step();
        dmem_ack = 1'b0;
        clear_in();
        check("t5_late_rdata", Read_data_MEM, 32'h0);
        check("t5_late_req", {31'h0, dmem_req}, 32'h0);
        check("t5_late_err", {31'h0, err_MEM}, 32'h0);

        // ack on the last permitted WAIT cycle wins over timeout
        acked_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0, 3, 32'h1357_2468);
        check("t5_race_err", {31'h0, err_MEM}, 32'h0);
        check("t5_race_rdata", Read_data_MEM, 32'h1357_2468);
        step();

        // 6. reset during WAIT
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0);
        step();
        check("t6_wait_req", {31'h0, dmem_req}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_req", {31'h0, dmem_req}, 32'h0);
        check("t6_rst_stall", {31'h0, stall_MEM}, 32'h0);
        check("t6_rst_rdata", Read_data_MEM, 32'h0);
        step();
        clear_in();
        rst_n = 1'b1;
        step();
        acked_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0500, 32'h0, 0, 32'hCAFE_F00D);
        check("t6_after_rdata", Read_data_MEM, 32'hCAFE_F00D);
        check("t6_after_err", {31'h0, err_MEM}, 32'h0);
        step();
        clear_in();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
